// File: rtl/adc_ad1_reader_if.sv
// Signal bundle between the dual-channel serial ADC reader and its host/ADC side.
// The master modport is the reader; the slave modport is the ADC plus consumer.
interface adc_ad1_reader_if;
    logic        enable;
    logic        adc_miso0;
    logic        adc_miso1;
    logic        adc_cs_out;
    logic        adc_sclk;
    logic [11:0] data0;
    logic [11:0] data1;
    logic        data_valid;
    logic        lead_err;
    logic        busy;

    modport master (
        input  enable, adc_miso0, adc_miso1,
        output adc_cs_out, adc_sclk, data0, data1, data_valid, lead_err, busy
    );

    modport slave (
        output enable, adc_miso0, adc_miso1,
        input  adc_cs_out, adc_sclk, data0, data1, data_valid, lead_err, busy
    );
endinterface

// File: rtl/adc_ad1_reader.sv
// Reads two 16-bit serial ADC channels in parallel (SPI-like, MSB first) and
// publishes the low 12 bits of each, flagging nonzero leading bits.
module adc_ad1_reader #(
    parameter int unsigned HALF_DIV     = 2,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    adc_ad1_reader_if.master adc
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

    localparam logic [7:0] HALF_LAST  = 8'(HALF_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

    state_t      state, state_n;
    logic [7:0]  div_cnt, div_cnt_n;
    logic [4:0]  half_cnt, half_cnt_n;
    logic [7:0]  quiet_cnt, quiet_cnt_n;
    logic        cs_next, sclk_next, capture;
    logic [15:0] shift0, shift1;

    always_comb begin
        state_n     = state;
        div_cnt_n   = div_cnt;
        half_cnt_n  = half_cnt;
        quiet_cnt_n = quiet_cnt;
        case (state)
            IDLE: begin
                if (adc.enable) begin
                    state_n   = SETUP;
                    div_cnt_n = '0;
                end
            end
            SETUP: begin
                if (div_cnt == HALF_LAST) begin
                    state_n    = SHIFT;
                    div_cnt_n  = '0;
                    half_cnt_n = '0;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            SHIFT: begin
                // Even half-periods are SCLK low, odd are high; 32 halves per frame.
                if (div_cnt == HALF_LAST) begin
                    div_cnt_n = '0;
                    if (half_cnt == 5'd31) state_n = DONE;
                    else                   half_cnt_n = half_cnt + 5'd1;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            DONE: begin
                state_n     = QUIET;
                quiet_cnt_n = '0;
            end
            QUIET: begin
                if (quiet_cnt == QUIET_LAST) state_n = IDLE;
                else                         quiet_cnt_n = quiet_cnt + 8'd1;
            end
            default: state_n = IDLE;
        endcase

        // Pins are registered from the next state so they line up with it.
        cs_next   = !(state_n == SETUP || state_n == SHIFT);
        sclk_next = !(state_n == SHIFT && !half_cnt_n[0]);
        capture   = adc.adc_sclk && !sclk_next;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state          <= IDLE;
            div_cnt        <= '0;
            half_cnt       <= '0;
            quiet_cnt      <= '0;
            shift0         <= '0;
            shift1         <= '0;
            adc.adc_cs_out <= 1'b1;
            adc.adc_sclk   <= 1'b1;
            adc.data0      <= '0;
            adc.data1      <= '0;
            adc.data_valid <= 1'b0;
            adc.lead_err   <= 1'b0;
        end else begin
            state          <= state_n;
            div_cnt        <= div_cnt_n;
            half_cnt       <= half_cnt_n;
            quiet_cnt      <= quiet_cnt_n;
            adc.adc_cs_out <= cs_next;
            adc.adc_sclk   <= sclk_next;
            adc.data_valid <= (state_n == DONE);
            if (capture) begin
                shift0 <= {shift0[14:0], adc.adc_miso0};
                shift1 <= {shift1[14:0], adc.adc_miso1};
            end
            if (state_n == DONE) begin
                adc.data0    <= shift0[11:0];
                adc.data1    <= shift1[11:0];
                adc.lead_err <= |{shift0[15:12], shift1[15:12]};
            end
        end
    end

    assign adc.busy = (state != IDLE);
endmodule

// File: tb/tb_adc_ad1_reader.sv
// Bench for adc_ad1_reader: a behavioural ADC per instance feeds random words,
// and frame timing plus published data are checked against those words.
module tb_adc_ad1_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        en [2];
    logic        miso0 [2];
    logic        miso1 [2];
    logic        cs_w [2];
    logic        sclk_w [2];
    logic        dv_w [2];
    logic        lead_w [2];
    logic        busy_w [2];
    logic [11:0] d0_w [2];
    logic [11:0] d1_w [2];
    logic [15:0] w0 [2];
    logic [15:0] w1 [2];
    logic [15:0] cur0 [2];
    logic [15:0] cur1 [2];
    logic        prev_cs [2];
    logic        prev_sclk [2];
    int          low_cnt [2], fall_cnt [2], high_cnt [2], nbit [2];
    int          low_len [2], falls [2], gap [2], frames [2], dv_cnt [2];
    int          checks = 0;
    int          errors = 0;

    adc_ad1_reader_if ifc [2] ();

    adc_ad1_reader #(.HALF_DIV(2), .QUIET_CYCLES(4)) dut_a (
        .clk(clk), .reset_b(rst[0]), .adc(ifc[0])
    );
    adc_ad1_reader #(.HALF_DIV(1), .QUIET_CYCLES(1)) dut_b (
        .clk(clk), .reset_b(rst[1]), .adc(ifc[1])
    );

    for (genvar g = 0; g < 2; g++) begin : wiring
        assign ifc[g].enable    = en[g];
        assign ifc[g].adc_miso0 = miso0[g];
        assign ifc[g].adc_miso1 = miso1[g];
        assign cs_w[g]   = ifc[g].adc_cs_out;
        assign sclk_w[g] = ifc[g].adc_sclk;
        assign dv_w[g]   = ifc[g].data_valid;
        assign lead_w[g] = ifc[g].lead_err;
        assign busy_w[g] = ifc[g].busy;
        assign d0_w[g]   = ifc[g].data0;
        assign d1_w[g]   = ifc[g].data1;
    end

    // ADC model (bit 15-n presented after the n-th SCLK fall) plus frame timing monitor.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                prev_cs[i] = 1'b1; prev_sclk[i] = 1'b1;
                low_cnt[i] = 0; fall_cnt[i] = 0; nbit[i] = 16;
                miso0[i] = 1'b0; miso1[i] = 1'b0;
            end else begin
                if (dv_w[i]) dv_cnt[i]++;
                if (cs_w[i]) begin
                    if (!prev_cs[i]) begin
                        low_len[i] = low_cnt[i]; falls[i] = fall_cnt[i]; high_cnt[i] = 1;
                    end else high_cnt[i]++;
                end else begin
                    if (prev_cs[i]) begin
                        gap[i] = high_cnt[i]; low_cnt[i] = 1; fall_cnt[i] = 0; frames[i]++;
                        cur0[i] = w0[i]; cur1[i] = w1[i]; nbit[i] = 0;
                    end else low_cnt[i]++;
                    if (prev_sclk[i] && !sclk_w[i]) begin
                        fall_cnt[i]++; nbit[i]++;
                    end
                    if (nbit[i] < 16) begin
                        miso0[i] = cur0[i][15-nbit[i]];
                        miso1[i] = cur1[i][15-nbit[i]];
                    end
                end
                prev_cs[i] = cs_w[i]; prev_sclk[i] = sclk_w[i];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_check(input int i, input int exp_low, input int exp_gap);
        bit got = 0;
        logic lead_exp;
        for (int k = 0; k < 600 && !got; k++) begin
            tick();
            if (dv_w[i] === 1'b1) got = 1;
        end
        check("dv_seen", 32'(got), 1);
        if (got) begin
            lead_exp = (cur0[i][15:12] != 4'd0) || (cur1[i][15:12] != 4'd0);
            check("data0", 32'(d0_w[i]), 32'(cur0[i][11:0]));
            check("data1", 32'(d1_w[i]), 32'(cur1[i][11:0]));
            check("lead_err", 32'(lead_w[i]), 32'(lead_exp));
            check("busy_done", 32'(busy_w[i]), 1);
            check("cs_low_len", 32'(low_len[i]), 32'(exp_low));
            check("sclk_falls", 32'(falls[i]), 16);
            if (exp_gap >= 0) check("cs_gap", 32'(gap[i]), 32'(exp_gap));
        end
    endtask

    task automatic wait_fall(input int i, input int n);
        bit hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            tick();
            if (!cs_w[i] && fall_cnt[i] == n) hit = 1;
        end
        check("fall_reached", 32'(hit), 1);
    endtask

    task automatic check_reset_outputs(input int i);
        check("rst_cs", 32'(cs_w[i]), 1);
        check("rst_sclk", 32'(sclk_w[i]), 1);
        check("rst_data0", 32'(d0_w[i]), 0);
        check("rst_data1", 32'(d1_w[i]), 0);
        check("rst_dv", 32'(dv_w[i]), 0);
        check("rst_lead", 32'(lead_w[i]), 0);
        check("rst_busy", 32'(busy_w[i]), 0);
    endtask

    initial begin
        int dvc;
        int fr;
        rst = '{1'b0, 1'b0}; en = '{1'b0, 1'b0};
        w0 = '{16'h0, 16'h0}; w1 = '{16'h0, 16'h0};
        repeat (3) tick();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick();

        w0[0] = 16'h09B2; w1[0] = 16'h03E8; en[0] = 1'b1;
        frame_check(0, 66, -1);
        check("d0_9B2", 32'(d0_w[0]), 32'h9B2);
        check("d1_3E8", 32'(d1_w[0]), 32'h3E8);
        check("lead_clear", 32'(lead_w[0]), 0);

        w1[0] = 16'h04D9;
        frame_check(0, 66, 6);
        check("d1_4D9", 32'(d1_w[0]), 32'h4D9);
        w1[0] = 16'h09B2;
        frame_check(0, 66, 6);
        check("d1_9B2", 32'(d1_w[0]), 32'h9B2);

        w0[0] = 16'h8001; w1[0] = 16'($urandom_range(0, 4095));
        frame_check(0, 66, 6);
        check("d0_001", 32'(d0_w[0]), 32'h001);
        check("lead_set", 32'(lead_w[0]), 1);
        w0[0] = 16'($urandom) & 16'h0FFF; w1[0] = 16'($urandom) & 16'h0FFF;
        repeat (3) tick();
        check("hold_dv", 32'(dv_w[0]), 0);
        check("hold_d0", 32'(d0_w[0]), 32'h001);
        check("hold_lead", 32'(lead_w[0]), 1);
        frame_check(0, 66, 6);
        check("lead_cleared", 32'(lead_w[0]), 0);

        for (int n = 0; n < 6; n++) begin
            w0[0] = 16'($urandom); w1[0] = 16'($urandom);
            frame_check(0, 66, 6);
        end

        // Abort a frame with reset at the 8th SCLK fall.
        w0[0] = 16'($urandom); w1[0] = 16'($urandom);
        wait_fall(0, 8);
        dvc = dv_cnt[0];
        rst[0] = 1'b0;
        #1;
        check_reset_outputs(0);
        repeat (4) tick();
        check("abort_no_dv", 32'(dv_cnt[0]), 32'(dvc));
        w0[0] = 16'($urandom); w1[0] = 16'($urandom);
        rst[0] = 1'b1;
        frame_check(0, 66, -1);

        // Drop enable during bit period 5.
        w0[0] = 16'($urandom); w1[0] = 16'($urandom);
        wait_fall(0, 5);
        en[0] = 1'b0;
        fr = frames[0];
        frame_check(0, 66, 6);
        dvc = dv_cnt[0];
        repeat (20) tick();
        check("stop_busy", 32'(busy_w[0]), 0);
        check("stop_cs", 32'(cs_w[0]), 1);
        check("stop_frames", 32'(frames[0]), 32'(fr));
        check("stop_dv", 32'(dv_cnt[0]), 32'(dvc));

        // Minimum divider and quiet time.
        w0[1] = 16'($urandom); w1[1] = 16'($urandom); en[1] = 1'b1;
        frame_check(1, 33, -1);
        for (int n = 0; n < 4; n++) begin
            w0[1] = 16'($urandom); w1[1] = 16'($urandom);
            frame_check(1, 33, 3);
        end
        en[1] = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
